multi_channel_trigger: RTL and testbench
========================================

Name: multi_channel_trigger

Overview:
- Parametrised trigger/run controller for the logic analyzer capture path; gates sample storage via o_trig.
- Trigger modes: single-channel edge, masked multi-channel pattern, edge AND pattern, or external only.
- Adds arm/holdoff/post-trigger sample counting and an IDLE/ARMED/RUN/DONE state machine.
- Manual toggle and abort retained.

Parameters:
- WIDTH, 8, number of data channels (>=2)
- CNT_W, 16, width of holdoff and post-trigger counters

Ports:
- i_clk  in  1  sample clock
- i_rst  in  1  asynchronous active-high reset
- i_data  in  WIDTH  channel samples (synchronous to i_clk)
- i_mode  in  2  0 edge, 1 pattern, 2 edge&pattern, 3 external only
- i_edge_sel  in  $clog2(WIDTH)  channel index for edge detection
- i_edge_pol  in  2  0 rising, 1 falling, 2 either, 3 never
- i_pat_mask  in  WIDTH  1 = channel participates in pattern
- i_pat_value  in  WIDTH  required level for masked channels
- i_ext_en  in  1  OR external trigger into modes 0-2 (mode 3 always uses it)
- i_ext_trig  in  1  external trigger, rising-edge detected
- i_arm  in  1  rising edge arms
- i_abort  in  1  rising edge returns to IDLE
- i_man_toggle  in  1  rising edge forces start (ARMED) or stop (RUN)
- i_holdoff  in  CNT_W  cycles after arming during which triggers are ignored
- i_post_count  in  CNT_W  RUN length in cycles; 0 = unlimited
- o_armed  out  1  high in ARMED
- o_trig  out  1  high in RUN
- o_trig_pulse  out  1  one-cycle pulse on the first RUN cycle
- o_done  out  1  high in DONE
- o_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (async, i_rst=1):
  - state IDLE; all outputs 0; holdoff counter 0.
  - Edge-detect history registers for i_data, i_ext_trig, i_arm, i_abort and i_man_toggle are 0.
- Edge detection: each control input is compared with its previous-cycle registered value. An input held high through reset release produces one edge in the first cycle after release.
- Edge condition (cycle n):
  - Uses d = i_data[i_edge_sel] and p = previous-cycle value of that channel.
  - Rising = d&~p; falling = ~d&p; either = d^p; never = 0.
- Pattern condition: ((i_data ^ i_pat_value) & i_pat_mask) == 0. A level test; a mask of all zeros always matches.
- hit, by mode:
  - mode0 = edge; mode1 = pattern; mode2 = edge & pattern.
  - Modes 0-2 additionally OR in (i_ext_en & ext rising).
  - mode3 = ext rising only.
- Configuration inputs are used live, except i_post_count, which is latched on entering RUN.
- State transitions; priority per cycle is abort > man_toggle > hit/count > arm:
  - IDLE -> ARMED on arm edge. Holdoff counter loads i_holdoff.
  - ARMED:
    - Holdoff counter decrements each cycle while nonzero.
    - hit is accepted only in cycles where the counter is 0. With i_holdoff=0, the first ARMED cycle already accepts.
    - Accepted hit or man_toggle edge -> RUN.
    - An arm edge while ARMED is ignored; it does not reload holdoff.
  - RUN:
    - o_count clears to 0 on entry, then increments by 1 each RUN cycle. It saturates at all-ones.
    - With a latched post count N>0, RUN lasts exactly N cycles, then -> DONE; o_count = N in DONE.
    - With N=0, RUN continues until man_toggle or abort.
    - man_toggle edge -> DONE. hit and arm are ignored.
  - DONE: holds o_count. Arm edge -> ARMED (reloads holdoff).
  - Any state: abort edge -> IDLE, with o_count cleared.
- Latency:
  - A hit observed in cycle n gives o_trig=1 and o_trig_pulse=1 in cycle n+1.
  - o_armed is high from the cycle after the arm edge.
- Simultaneous events:
  - abort+toggle in the same cycle -> IDLE.
  - toggle+hit in ARMED -> RUN (single entry; o_trig_pulse once).
  - Count expiry + toggle in the same RUN cycle -> DONE.
- Reset asserted mid-RUN: all outputs drop asynchronously.
- Re-triggering requires a new arm edge. A hit in IDLE or DONE has no effect.

Test Plan:
- WIDTH=8, mode0, sel=3, pol=rising, holdoff=0, post=4; arm, then ch3 0->1 in cycle n -> o_trig high n+1..n+4, o_trig_pulse at n+1 only, o_done from n+5, o_count=4.
- mode1, mask=0xF0, value=0xA0; drive 0x5A then 0xAF -> no trigger on 0x5A; RUN one cycle after 0xAF appears.
- holdoff=10, mode0 pol=either; toggle ch0 every cycle after arm -> first RUN cycle exactly 12 cycles after the arm edge (10 holdoff cycles, hit in cycle 11).
- post=0, ext trigger in mode3 (ext rising) -> RUN indefinitely (run ≥300 cycles), o_count increments each cycle; man_toggle edge -> DONE next cycle, count frozen.
- Abort and man_toggle edges in the same cycle during RUN -> IDLE, o_count=0; arm edge and hit in the same cycle from IDLE -> ARMED only, no RUN.
- Assert i_rst asynchronously mid-RUN -> all outputs 0 immediately; release with i_arm held high -> ARMED one cycle after release.

Source files
------------

// File: rtl/multi_channel_trigger.sv
// Trigger/run controller for the logic analyzer capture path.
// Watches the sampled channels for an edge, a masked pattern, both, or an
// external trigger, and walks IDLE -> ARMED -> RUN -> DONE. o_trig gates
// sample storage while in RUN. Holdoff suppresses triggers right after
// arming, and a latched post-trigger count bounds the RUN length.
// o_state exposes the FSM state for debug and checker binding.
module multi_channel_trigger #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [1:0]               i_mode,
    input  logic [$clog2(WIDTH)-1:0] i_edge_sel,
    input  logic [1:0]               i_edge_pol,
    input  logic [WIDTH-1:0]         i_pat_mask,
    input  logic [WIDTH-1:0]         i_pat_value,
    input  logic                     i_ext_en,
    input  logic                     i_ext_trig,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic                     i_man_toggle,
    input  logic [CNT_W-1:0]         i_holdoff,
    input  logic [CNT_W-1:0]         i_post_count,
    output logic                     o_armed,
    output logic                     o_trig,
    output logic                     o_trig_pulse,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_count,
    output logic [1:0]               o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic               pulse_q, pulse_d;

    // Previous-cycle copies of the inputs; reset to 0 so an input held high
    // across reset release shows up as one edge.
    logic [WIDTH-1:0]   data_q;
    logic               ext_q, arm_q, abort_q, tog_q;

    logic ext_edge, arm_edge, abort_edge, tog_edge;
    logic d_cur, d_prev, edge_hit, pat_hit, hit;
    logic [CNT_W-1:0] cnt_inc;

    assign ext_edge   = i_ext_trig   & ~ext_q;
    assign arm_edge   = i_arm        & ~arm_q;
    assign abort_edge = i_abort      & ~abort_q;
    assign tog_edge   = i_man_toggle & ~tog_q;

    assign d_cur   = i_data[i_edge_sel];
    assign d_prev  = data_q[i_edge_sel];
    assign pat_hit = (((i_data ^ i_pat_value) & i_pat_mask) == '0);

    // RUN counter saturates at all-ones instead of wrapping.
    assign cnt_inc = (count_q == '1) ? count_q : (count_q + CNT_ONE);

    // Trigger condition for this cycle, from the live configuration.
    always_comb begin
        edge_hit = 1'b0;
        hit      = 1'b0;
        unique case (i_edge_pol)
            2'd0:    edge_hit = d_cur & ~d_prev;
            2'd1:    edge_hit = ~d_cur & d_prev;
            2'd2:    edge_hit = d_cur ^ d_prev;
            default: edge_hit = 1'b0;
        endcase
        unique case (i_mode)
            2'd0:    hit = edge_hit | (i_ext_en & ext_edge);
            2'd1:    hit = pat_hit | (i_ext_en & ext_edge);
            2'd2:    hit = (edge_hit & pat_hit) | (i_ext_en & ext_edge);
            default: hit = ext_edge;
        endcase
    end

    // Next state and counters; abort beats toggle beats hit/expiry beats arm.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        post_d  = post_q;
        pulse_d = 1'b0;
        if (abort_edge) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (tog_edge || arm_edge) begin
                        state_d = S_ARMED;
                        hold_d  = i_holdoff;
                    end
                end
                S_ARMED: begin
                    // A repeated arm edge here deliberately does not reload holdoff.
                    if (tog_edge || (hit && (hold_q == '0))) begin
                        state_d = S_RUN;
                        count_d = '0;
                        post_d  = i_post_count;
                        pulse_d = 1'b1;
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - CNT_ONE;
                    end
                end
                S_RUN: begin
                    count_d = cnt_inc;
                    if (tog_edge || ((post_q != '0) && (cnt_inc == post_q))) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (tog_edge || arm_edge) begin
                        state_d = S_ARMED;
                        hold_d  = i_holdoff;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and input history registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            count_q <= '0;
            post_q  <= '0;
            pulse_q <= 1'b0;
            data_q  <= '0;
            ext_q   <= 1'b0;
            arm_q   <= 1'b0;
            abort_q <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            post_q  <= post_d;
            pulse_q <= pulse_d;
            data_q  <= i_data;
            ext_q   <= i_ext_trig;
            arm_q   <= i_arm;
            abort_q <= i_abort;
            tog_q   <= i_man_toggle;
        end
    end

    assign o_armed      = (state_q == S_ARMED);
    assign o_trig       = (state_q == S_RUN);
    assign o_done       = (state_q == S_DONE);
    assign o_trig_pulse = pulse_q;
    assign o_count      = count_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_multi_channel_trigger.sv
// Bench for multi_channel_trigger: directed scenarios plus a randomized
// stretch, every cycle scored against a reference model held in the bench.
module tb_multi_channel_trigger;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int OUT_W = CNT_W + 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int ST_IDLE  = 0;
    localparam int ST_ARMED = 1;
    localparam int ST_RUN   = 2;
    localparam int ST_DONE  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   i_data;
    logic [1:0]         i_mode;
    logic [2:0]         i_edge_sel;
    logic [1:0]         i_edge_pol;
    logic [WIDTH-1:0]   i_pat_mask;
    logic [WIDTH-1:0]   i_pat_value;
    logic               i_ext_en, i_ext_trig, i_arm, i_abort, i_man_toggle;
    logic [CNT_W-1:0]   i_holdoff, i_post_count;
    logic               o_armed, o_trig, o_trig_pulse, o_done;
    logic [CNT_W-1:0]   o_count;
    logic [1:0]         dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [OUT_W-1:0] exp_q[$];

    // Reference model state (plain integers, spec-level behaviour)
    int               m_state;
    int               m_hold;
    int               m_cnt;
    int               m_post;
    logic [WIDTH-1:0] m_prev_data;
    logic             m_prev_ext, m_prev_arm, m_prev_abort, m_prev_tog;

    // Clock / reset block
    always #5 clk = ~clk;

    multi_channel_trigger #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (i_data),
        .i_mode       (i_mode),
        .i_edge_sel   (i_edge_sel),
        .i_edge_pol   (i_edge_pol),
        .i_pat_mask   (i_pat_mask),
        .i_pat_value  (i_pat_value),
        .i_ext_en     (i_ext_en),
        .i_ext_trig   (i_ext_trig),
        .i_arm        (i_arm),
        .i_abort      (i_abort),
        .i_man_toggle (i_man_toggle),
        .i_holdoff    (i_holdoff),
        .i_post_count (i_post_count),
        .o_armed      (o_armed),
        .o_trig       (o_trig),
        .o_trig_pulse (o_trig_pulse),
        .o_done       (o_done),
        .o_count      (o_count),
        .o_state      (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state      = ST_IDLE;
        m_hold       = 0;
        m_cnt        = 0;
        m_post       = 0;
        m_prev_data  = '0;
        m_prev_ext   = 1'b0;
        m_prev_arm   = 1'b0;
        m_prev_abort = 1'b0;
        m_prev_tog   = 1'b0;
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        logic d, p, e_hit, pat, ext_r, arm_e, ab_e, tg_e, hit, pulse;
        ext_r = i_ext_trig && !m_prev_ext;
        arm_e = i_arm && !m_prev_arm;
        ab_e  = i_abort && !m_prev_abort;
        tg_e  = i_man_toggle && !m_prev_tog;
        d     = i_data[i_edge_sel];
        p     = m_prev_data[i_edge_sel];
        case (i_edge_pol)
            2'd0:    e_hit = d && !p;
            2'd1:    e_hit = !d && p;
            2'd2:    e_hit = (d != p);
            default: e_hit = 1'b0;
        endcase
        pat = (((i_data ^ i_pat_value) & i_pat_mask) == '0);
        if (i_mode == 2'd3) begin
            hit = ext_r;
        end else begin
            case (i_mode)
                2'd0:    hit = e_hit;
                2'd1:    hit = pat;
                default: hit = e_hit && pat;
            endcase
            hit = hit || (i_ext_en && ext_r);
        end
        pulse = 1'b0;
        if (ab_e) begin
            m_state = ST_IDLE;
            m_cnt   = 0;
        end else if (m_state == ST_IDLE || m_state == ST_DONE) begin
            if (tg_e || arm_e) begin
                m_state = ST_ARMED;
                m_hold  = int'(i_holdoff);
            end
        end else if (m_state == ST_ARMED) begin
            if (tg_e || (hit && m_hold == 0)) begin
                m_state = ST_RUN;
                m_cnt   = 0;
                m_post  = int'(i_post_count);
                pulse   = 1'b1;
            end else if (m_hold > 0) begin
                m_hold--;
            end
        end else begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (tg_e || (m_post != 0 && m_cnt == m_post)) m_state = ST_DONE;
        end
        m_prev_data  = i_data;
        m_prev_ext   = i_ext_trig;
        m_prev_arm   = i_arm;
        m_prev_abort = i_abort;
        m_prev_tog   = i_man_toggle;
        exp_q.push_back({m_state == ST_ARMED, m_state == ST_RUN, pulse,
                         m_state == ST_DONE, CNT_W'(m_cnt)});
    endtask

    // Driver: called at a negedge; applies inputs for the next posedge.
    task automatic cyc(input logic [WIDTH-1:0] data, input logic ext, input logic arm,
                       input logic abort, input logic tog);
        i_data       = data;
        i_ext_trig   = ext;
        i_arm        = arm;
        i_abort      = abort;
        i_man_toggle = tog;
        model_step();
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [2:0] sel, input logic [1:0] pol,
                           input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] value,
                           input logic ext_en, input int holdoff, input int post);
        i_mode       = mode;
        i_edge_sel   = sel;
        i_edge_pol   = pol;
        i_pat_mask   = mask;
        i_pat_value  = value;
        i_ext_en     = ext_en;
        i_holdoff    = CNT_W'(holdoff);
        i_post_count = CNT_W'(post);
    endtask

    // Monitor / scoreboard: one expected output set per clock edge.
    initial begin
        logic [OUT_W-1:0] e;
        logic [OUT_W-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {o_armed, o_trig, o_trig_pulse, o_done, o_count};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle_out actual=%h expected=%h (armed,trig,pulse,done,count) at %0t",
                             a, e, $time);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int first_run;
        rst = 1'b1;
        set_cfg(2'd0, 3'd3, 2'd0, 8'h00, 8'h00, 1'b0, 0, 4);
        i_data = '0; i_ext_trig = 0; i_arm = 0; i_abort = 0; i_man_toggle = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_armed", o_armed, 0);
        check("reset_trig", o_trig, 0);
        check("reset_pulse", o_trig_pulse, 0);
        check("reset_done", o_done, 0);
        check("reset_count", o_count, 0);
        rst = 1'b0;

        // 1: edge mode, ch3 rising, post=4
        cyc(8'h00, 0, 1, 0, 0);
        check("t1_armed", o_armed, 1);
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h08, 0, 0, 0, 0);
        check("t1_trig_n1", o_trig, 1);
        check("t1_pulse_n1", o_trig_pulse, 1);
        cyc(8'h08, 0, 0, 0, 0);
        check("t1_pulse_n2", o_trig_pulse, 0);
        cyc(8'h08, 0, 0, 0, 0);
        cyc(8'h08, 0, 0, 0, 0);
        check("t1_trig_n4", o_trig, 1);
        cyc(8'h08, 0, 0, 0, 0);
        check("t1_done", o_done, 1);
        check("t1_count", o_count, 4);
        cyc(8'h00, 0, 0, 1, 0);
        check("t1_abort_idle", o_done, 0);
        cyc(8'h00, 0, 0, 0, 0);

        // 2: pattern mode, mask F0 value A0
        set_cfg(2'd1, 3'd0, 2'd0, 8'hF0, 8'hA0, 1'b0, 0, 4);
        cyc(8'h00, 0, 1, 0, 0);
        cyc(8'h5A, 0, 0, 0, 0);
        check("t2_no_trig_5a", o_trig, 0);
        cyc(8'hAF, 0, 0, 0, 0);
        check("t2_trig_af", o_trig, 1);
        cyc(8'hAF, 0, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 0);

        // 3: holdoff=10, ch0 either edge toggling every cycle
        set_cfg(2'd0, 3'd0, 2'd2, 8'h00, 8'h00, 1'b0, 10, 4);
        cyc(8'h00, 0, 1, 0, 0);
        first_run = -1;
        for (int k = 1; k <= 30; k++) begin
            cyc({7'd0, k[0]}, 0, 0, 0, 0);
            if (o_trig && first_run < 0) first_run = k + 1;
            if (first_run >= 0) break;
        end
        check("t3_first_run_cycle", first_run, 12);
        cyc(8'h00, 0, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 0);

        // 4: external only, unlimited run, stop by toggle
        set_cfg(2'd3, 3'd0, 2'd0, 8'h00, 8'h00, 1'b0, 0, 0);
        cyc(8'h00, 0, 1, 0, 0);
        cyc(8'h00, 1, 0, 0, 0);
        check("t4_trig", o_trig, 1);
        for (int k = 0; k < 300; k++) cyc(WIDTH'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        check("t4_still_run", o_trig, 1);
        check("t4_count300", o_count, 300);
        cyc(8'h00, 0, 0, 0, 1);
        check("t4_done", o_done, 1);
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        check("t4_count_frozen", o_count, 301);

        // 5: abort+toggle in RUN -> IDLE; arm+hit from IDLE -> ARMED only
        cyc(8'h00, 0, 1, 0, 0);
        cyc(8'h00, 1, 0, 0, 1);
        check("t5_toggle_hit_run", o_trig, 1);
        check("t5_toggle_hit_pulse", o_trig_pulse, 1);
        cyc(8'h00, 0, 0, 0, 0);
        check("t5_single_pulse", o_trig_pulse, 0);
        cyc(8'h00, 0, 0, 1, 1);
        check("t5_abort_idle", {o_armed, o_trig, o_done}, 0);
        check("t5_abort_count", o_count, 0);
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 1, 1, 0, 0);
        check("t5_arm_hit_armed", o_armed, 1);
        check("t5_arm_hit_no_run", o_trig, 0);
        cyc(8'h00, 1, 0, 0, 0);
        check("t5_no_late_run", o_trig, 0);

        // 6: async reset mid-RUN, release with arm held high
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 1, 0, 0, 0);
        cyc(8'h00, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_armed", o_armed, 0);
        check("t6_rst_trig", o_trig, 0);
        check("t6_rst_done", o_done, 0);
        check("t6_rst_count", o_count, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h00, 0, 1, 0, 0);
        check("t6_armed_after_release", o_armed, 1);
        cyc(8'h00, 0, 1, 0, 0);
        cyc(8'h00, 0, 0, 1, 0);

        // 7: randomized stimulus and live configuration
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) begin
                set_cfg(2'($urandom), 3'($urandom), 2'($urandom), WIDTH'($urandom),
                        WIDTH'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 8));
            end
            cyc(WIDTH'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 24) == 0);
        end

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
